// File: rtl/mmu_bd_arb_if.sv
// rtl/mmu_bd_arb_if.sv - BD stream bundle: CH_NUM source channels plus the merged output
// master = BD sources and mmu_rx side, slave = the arbiter.
interface mmu_bd_arb_if #(
   parameter int CH_NUM = 2,
   parameter int D_W    = 512,
   parameter int U_W    = 60,
   parameter int K_W    = 64
);
   logic [CH_NUM*D_W-1:0] s_axis_tdata;
   logic [CH_NUM*U_W-1:0] s_axis_tuser;
   logic [CH_NUM*K_W-1:0] s_axis_tkeep;
   logic [CH_NUM-1:0]     s_axis_tlast;
   logic [CH_NUM-1:0]     s_axis_tvalid;
   logic [CH_NUM-1:0]     s_axis_tready;
   logic [D_W-1:0]        m_axis_tdata;
   logic [U_W-1:0]        m_axis_tuser;
   logic [K_W-1:0]        m_axis_tkeep;
   logic                  m_axis_tlast;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;

   modport master (
      output s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
      input  s_axis_tready,
      input  m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
      output m_axis_tready
   );

   modport slave (
      input  s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
      output s_axis_tready,
      output m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
      input  m_axis_tready
   );
endinterface

// File: rtl/mmu_bd_arb.sv
// rtl/mmu_bd_arb.sv - packet-atomic N-channel BD arbiter in front of mmu_rx
// Round-robin or fixed priority, per-channel enable, packet and stall counters on a CPU page.
module mmu_bd_arb #(
   parameter int          CH_NUM     = 2,
   parameter int          D_W        = 512,
   parameter int          U_W        = 60,
   parameter int          K_W        = 64,
   parameter int          A_WTH      = 24,
   parameter int          D_WTH      = 32,
   parameter logic [11:0] REG_ARB_ID = 12'd3
) (
   input  logic             clk_sys,
   input  logic             rst,
   mmu_bd_arb_if.slave      bd,
   input  logic             cnt_reg_clr,
   input  logic [A_WTH-1:0] cpu_addr,
   input  logic [D_WTH-1:0] cpu_data_in,
   input  logic             cpu_wr,
   input  logic             cpu_rd,
   output logic [D_WTH-1:0] cpu_data_out_arb
);
   localparam int GW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   typedef enum logic {IDLE, XFER} state_t;

   state_t                  state;
   logic [GW-1:0]           grant;
   logic [GW-1:0]           rr_ptr;
   logic [GW-1:0]           nxt_grant;
   logic [GW-1:0]           grant_inc;
   logic [GW:0]             rr_sum;
   logic                    grant_mode;
   logic                    mode;
   logic [CH_NUM-1:0]       en_mask;
   logic [CH_NUM-1:0]       req;
   logic [CH_NUM-1:0][31:0] pkt_cnt;
   logic [31:0]             stall_cnt;
   logic [D_WTH-1:0]        rd_data;
   logic                    move;
   logic                    beat_acc;
   logic                    pkt_end;
   logic                    page_hit;
   logic [11:0]             offset;
   logic                    unused_bits;

   assign req       = bd.s_axis_tvalid & en_mask;
   assign move      = !bd.m_axis_tvalid || bd.m_axis_tready;
   assign beat_acc  = (state == XFER) && bd.s_axis_tvalid[grant] && move;
   assign pkt_end   = beat_acc && bd.s_axis_tlast[grant];
   assign grant_inc = (int'(grant) == CH_NUM - 1) ? '0 : grant + 1'b1;
   assign page_hit  = cpu_addr[A_WTH-1:12] == (A_WTH-12)'(REG_ARB_ID);
   assign offset    = cpu_addr[11:0];
   assign unused_bits = ^{cpu_data_in[7:1], cpu_data_in[D_WTH-1:8+CH_NUM]};

   always_comb begin
      bd.s_axis_tready = '0;
      if (state == XFER) bd.s_axis_tready[grant] = move;
   end

   // Scan downward so the last hit wins: the first requester at or above rr_ptr (mode 0) or the lowest index (mode 1).
   always_comb begin
      nxt_grant = '0;
      rr_sum    = '0;
      for (int k = CH_NUM - 1; k >= 0; k--) begin
         rr_sum = {1'b0, rr_ptr} + (GW+1)'(k);
         if (rr_sum >= (GW+1)'(CH_NUM)) rr_sum = rr_sum - (GW+1)'(CH_NUM);
         if (mode) begin
            if (req[k]) nxt_grant = GW'(k);
         end else if (req[rr_sum[GW-1:0]]) begin
            nxt_grant = rr_sum[GW-1:0];
         end
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         grant            <= '0;
         rr_ptr           <= '0;
         grant_mode       <= 1'b0;
         bd.m_axis_tdata  <= '0;
         bd.m_axis_tuser  <= '0;
         bd.m_axis_tkeep  <= '0;
         bd.m_axis_tlast  <= 1'b0;
         bd.m_axis_tvalid <= 1'b0;
      end else begin
         if (beat_acc) begin
            bd.m_axis_tdata  <= bd.s_axis_tdata[int'(grant)*D_W +: D_W];
            bd.m_axis_tuser  <= bd.s_axis_tuser[int'(grant)*U_W +: U_W];
            bd.m_axis_tkeep  <= bd.s_axis_tkeep[int'(grant)*K_W +: K_W];
            bd.m_axis_tlast  <= bd.s_axis_tlast[grant];
            bd.m_axis_tvalid <= 1'b1;
         end else if (bd.m_axis_tready) begin
            bd.m_axis_tvalid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (|req) begin
                  grant      <= nxt_grant;
                  grant_mode <= mode;
                  state      <= XFER;
               end
            end
            XFER: begin
               // Mode is frozen at grant time so a mid-packet ctrl write cannot move rr_ptr.
               if (pkt_end) begin
                  state <= IDLE;
                  if (!grant_mode) rr_ptr <= grant_inc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         pkt_cnt   <= '0;
         stall_cnt <= '0;
      end else if (cnt_reg_clr) begin
         pkt_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         if (pkt_end) pkt_cnt[grant] <= pkt_cnt[grant] + 32'd1;
         if (bd.m_axis_tvalid && !bd.m_axis_tready) stall_cnt <= stall_cnt + 32'd1;
      end
   end

   always_comb begin
      rd_data = '0;
      case (offset)
         12'h000: begin
            rd_data[0]           = mode;
            rd_data[8 +: CH_NUM] = en_mask;
         end
         12'h004: begin
            rd_data[0]       = (state == XFER);
            rd_data[4 +: GW] = grant;
            rd_data[8 +: GW] = rr_ptr;
         end
         12'h008: rd_data = D_WTH'(stall_cnt);
         default: begin
            for (int i = 0; i < CH_NUM; i++) begin
               if (offset == 12'(16 + 4 * i)) rd_data = D_WTH'(pkt_cnt[i]);
            end
         end
      endcase
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         mode             <= 1'b0;
         en_mask          <= '1;
         cpu_data_out_arb <= '0;
      end else begin
         if (cpu_wr && page_hit && offset == 12'h000) begin
            mode    <= cpu_data_in[0];
            en_mask <= cpu_data_in[8 +: CH_NUM];
         end
         if (cpu_rd && page_hit) cpu_data_out_arb <= rd_data;
      end
   end
endmodule

// File: tb/tb_mmu_bd_arb.sv
// tb/tb_mmu_bd_arb.sv - scoreboard bench for mmu_bd_arb
// Sources push expected beats on input handshake; the output monitor pops and compares.
module tb_mmu_bd_arb;
   localparam int CH    = 2;
   localparam int D_W   = 512;
   localparam int U_W   = 60;
   localparam int K_W   = 64;
   localparam int A_WTH = 24;
   localparam int D_WTH = 32;

   typedef struct packed {
      logic [D_W-1:0] data;
      logic [U_W-1:0] user;
      logic [K_W-1:0] keep;
      logic           last;
   } beat_t;

   logic             clk_sys     = 1'b0;
   logic             rst         = 1'b1;
   logic             cnt_reg_clr = 1'b0;
   logic [A_WTH-1:0] cpu_addr    = '0;
   logic [D_WTH-1:0] cpu_data_in = '0;
   logic             cpu_wr      = 1'b0;
   logic             cpu_rd      = 1'b0;
   logic [D_WTH-1:0] cpu_data_out_arb;

   mmu_bd_arb_if #(.CH_NUM(CH), .D_W(D_W), .U_W(U_W), .K_W(K_W)) bd ();

   mmu_bd_arb #(
      .CH_NUM(CH), .D_W(D_W), .U_W(U_W), .K_W(K_W),
      .A_WTH(A_WTH), .D_WTH(D_WTH), .REG_ARB_ID(12'd3)
   ) dut (
      .clk_sys(clk_sys),
      .rst(rst),
      .bd(bd),
      .cnt_reg_clr(cnt_reg_clr),
      .cpu_addr(cpu_addr),
      .cpu_data_in(cpu_data_in),
      .cpu_wr(cpu_wr),
      .cpu_rd(cpu_rd),
      .cpu_data_out_arb(cpu_data_out_arb)
   );

   always #5 clk_sys = ~clk_sys;

   int          n_cmp = 0;
   int          n_err = 0;
   int unsigned cyc   = 0;
   beat_t       exp_q[$];
   int          pend[CH][$];
   int          out_cyc[$];
   int          out_ch[$];
   int          active[CH];
   int          len[CH];
   int          bidx[CH];
   int          pktno[CH];
   int          pkt_start[CH];
   logic [CH-1:0] hs = '0;
   beat_t       mon_e, mon_cur, mon_held;
   logic        mon_stalled = 1'b0;

   task automatic chk(input string tag, input logic [639:0] act, input logic [639:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic beat_t make_beat(input int c, input int p, input int b, input logic l);
      beat_t r;
      logic [31:0] w;
      w      = {8'(c), 16'(p), 8'(b)};
      r.data = {(D_W/32){w}};
      r.user = {w ^ 32'h5a5a_00ff, 28'h0c0ffee};
      r.keep = {K_W{1'b1}} >> b;
      r.last = l;
      return r;
   endfunction

   always @(posedge clk_sys) cyc <= cyc + 1;

   // Source driver: one packet at a time per channel, advancing on the handshake seen at the previous negedge.
   initial begin
      beat_t b;
      bd.s_axis_tdata  = '0;
      bd.s_axis_tuser  = '0;
      bd.s_axis_tkeep  = '0;
      bd.s_axis_tlast  = '0;
      bd.s_axis_tvalid = '0;
      for (int c = 0; c < CH; c++) begin
         active[c] = 0; len[c] = 0; bidx[c] = 0; pktno[c] = 0; pkt_start[c] = 0;
      end
      forever begin
         @(posedge clk_sys);
         #1;
         for (int c = 0; c < CH; c++) begin
            if (rst) begin
               active[c] = 0;
               pend[c].delete();
            end else begin
               if (hs[c]) begin
                  bidx[c]++;
                  if (bidx[c] == len[c]) begin
                     active[c] = 0;
                     pktno[c]++;
                  end
               end
               if (active[c] == 0 && pend[c].size() > 0) begin
                  len[c]       = pend[c].pop_front();
                  bidx[c]      = 0;
                  active[c]    = 1;
                  pkt_start[c] = int'(cyc);
               end
            end
            b = make_beat(c, pktno[c], bidx[c], bidx[c] == len[c] - 1);
            bd.s_axis_tdata[c*D_W +: D_W] = (active[c] != 0) ? b.data : '0;
            bd.s_axis_tuser[c*U_W +: U_W] = (active[c] != 0) ? b.user : '0;
            bd.s_axis_tkeep[c*K_W +: K_W] = (active[c] != 0) ? b.keep : '0;
            bd.s_axis_tlast[c]            = (active[c] != 0) && b.last;
            bd.s_axis_tvalid[c]           = (active[c] != 0);
         end
      end
   end

   always @(negedge clk_sys) begin
      if (rst) begin
         exp_q.delete();
         hs          = '0;
         mon_stalled = 1'b0;
      end else begin
         mon_cur = {bd.m_axis_tdata, bd.m_axis_tuser, bd.m_axis_tkeep, bd.m_axis_tlast};
         if (mon_stalled) chk("stable", mon_cur, mon_held);
         if (bd.m_axis_tvalid && bd.m_axis_tready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("tdata", mon_cur.data, mon_e.data);
               chk("tuser", mon_cur.user, mon_e.user);
               chk("tkeep", mon_cur.keep, mon_e.keep);
               chk("tlast", mon_cur.last, mon_e.last);
            end
            out_cyc.push_back(int'(cyc));
            if (bd.m_axis_tlast) out_ch.push_back(int'(bd.m_axis_tdata[31:24]));
         end
         mon_stalled = bd.m_axis_tvalid && !bd.m_axis_tready;
         mon_held    = mon_cur;
         hs          = bd.s_axis_tvalid & bd.s_axis_tready;
         for (int c = 0; c < CH; c++) begin
            if (hs[c]) exp_q.push_back(make_beat(c, pktno[c], bidx[c], bidx[c] == len[c] - 1));
         end
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #2;
   endtask

   task automatic cpu_write(input logic [11:0] off, input logic [31:0] d);
      cpu_addr    = {12'd3, off};
      cpu_data_in = d;
      cpu_wr      = 1'b1;
      tick();
      cpu_wr      = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [11:0] off, input logic [31:0] exp);
      cpu_addr = {12'd3, off};
      cpu_rd   = 1'b1;
      tick();
      cpu_rd   = 1'b0;
      chk(tag, cpu_data_out_arb, exp);
   endtask

   task automatic clr_cnt();
      cnt_reg_clr = 1'b1;
      tick();
      cnt_reg_clr = 1'b0;
   endtask

   task automatic clr_out();
      out_cyc.delete();
      out_ch.delete();
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (n < 2000 && !(pend[0].size() == 0 && pend[1].size() == 0 && active[0] == 0 &&
                           active[1] == 0 && exp_q.size() == 0 && !bd.m_axis_tvalid)) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, n >= 2000, 0);
   endtask

   task automatic wait_outs(input string tag, input int want);
      int n = 0;
      while (n < 2000 && out_ch.size() < want) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, n >= 2000, 0);
   endtask

   initial begin
      int n;
      bd.m_axis_tready = 1'b1;
      repeat (3) tick();
      chk("rst_m_tvalid", bd.m_axis_tvalid, 0);
      chk("rst_s_tready", bd.s_axis_tready, 0);
      chk("rst_rdata", cpu_data_out_arb, 0);
      rst = 1'b0;
      tick();
      rd_chk("ctrl_rst", 12'h000, 32'h0000_0300);
      rd_chk("status_rst", 12'h004, 32'h0);
      rd_chk("unmapped", 12'h00C, 32'h0);
      cpu_addr = 24'h004000; cpu_data_in = 32'h1; cpu_wr = 1'b1;
      tick();
      cpu_wr = 1'b0;
      cpu_write(12'h008, 32'h55);
      rd_chk("ctrl_other_page", 12'h000, 32'h0000_0300);
      rd_chk("stall_ro", 12'h008, 32'h0);

      // single 3-beat packet: latency and counter
      clr_out();
      pend[0].push_back(3);
      wait_done("t1");
      chk("t1_nbeats", out_cyc.size(), 3);
      for (int i = 0; i < out_cyc.size(); i++) chk("t1_latency", out_cyc[i] - pkt_start[0], i + 2);
      rd_chk("t1_pkt0", 12'h010, 32'd1);
      rd_chk("t1_status", 12'h004, 32'h0000_0100);
      pend[1].push_back(1);
      wait_done("t1b");
      rd_chk("t1b_status", 12'h004, 32'h0000_0010);

      // round robin with both channels busy
      clr_cnt();
      clr_out();
      pend[0].push_back(2); pend[0].push_back(2);
      pend[1].push_back(2); pend[1].push_back(2);
      wait_done("t2");
      chk("t2_npkts", out_ch.size(), 4);
      for (int i = 0; i < out_ch.size(); i++) chk("t2_order", out_ch[i], i % 2);
      chk("t2_burst", out_cyc[1] - out_cyc[0], 1);
      chk("t2_bubble", out_cyc[2] - out_cyc[1], 2);
      rd_chk("t2_pkt0", 12'h010, 32'd2);
      rd_chk("t2_pkt1", 12'h014, 32'd2);

      // fixed priority, then mask ch0 mid-packet
      clr_cnt();
      cpu_write(12'h000, 32'h0000_0301);
      clr_out();
      pend[0].push_back(4); pend[0].push_back(4); pend[0].push_back(4); pend[0].push_back(4);
      pend[1].push_back(2); pend[1].push_back(2);
      wait_outs("t3a", 2);
      cpu_write(12'h000, 32'h0000_0201);
      rd_chk("t3_pkt1_mid", 12'h014, 32'd0);
      wait_outs("t3b", 5);
      repeat (10) tick();
      chk("t3_masked_npkts", out_ch.size(), 5);
      chk("t3_masked_tready", bd.s_axis_tready, 0);
      cpu_write(12'h000, 32'h0000_0300);
      wait_done("t3");
      chk("t3_npkts", out_ch.size(), 6);
      for (int i = 0; i < out_ch.size(); i++) chk("t3_order", out_ch[i], (i == 3 || i == 4) ? 1 : 0);
      rd_chk("t3_pkt0", 12'h010, 32'd4);
      rd_chk("t3_pkt1", 12'h014, 32'd2);

      // back-pressure 1,0,0,1 during a 4-beat packet
      clr_cnt();
      clr_out();
      pend[0].push_back(4);
      n = 0;
      while (n < 200 && !bd.m_axis_tvalid) begin tick(); n++; end
      chk("t4_timeout", n >= 200, 0);
      tick();
      bd.m_axis_tready = 1'b0;
      tick();
      tick();
      bd.m_axis_tready = 1'b1;
      wait_done("t4");
      chk("t4_nbeats", out_cyc.size(), 4);
      rd_chk("t4_stall", 12'h008, 32'd2);

      // counter wrap and clear priority
      clr_cnt();
      force dut.pkt_cnt = {32'd0, 32'hFFFF_FFFF};
      tick();
      release dut.pkt_cnt;
      rd_chk("t5_pre", 12'h010, 32'hFFFF_FFFF);
      pend[0].push_back(1);
      wait_done("t5a");
      rd_chk("t5_wrap", 12'h010, 32'd0);
      rd_chk("t5_pkt1", 12'h014, 32'd0);
      pend[0].push_back(1);
      wait_done("t5b");
      rd_chk("t5_inc", 12'h010, 32'd1);
      pend[0].push_back(2);
      n = 0;
      while (n < 200 && !(bd.s_axis_tvalid[0] && bd.s_axis_tready[0] && bd.s_axis_tlast[0])) begin
         tick();
         n++;
      end
      chk("t5c_timeout", n >= 200, 0);
      clr_cnt();
      wait_done("t5c");
      rd_chk("t5_clr", 12'h010, 32'd0);

      // reset in the middle of a ch1 packet
      cpu_write(12'h000, 32'h0000_0301);
      clr_out();
      pend[1].push_back(4);
      n = 0;
      while (n < 200 && out_cyc.size() < 1) begin tick(); n++; end
      chk("t6_timeout", n >= 200, 0);
      rst = 1'b1;
      #1;
      chk("t6_m_tvalid", bd.m_axis_tvalid, 0);
      chk("t6_s_tready", bd.s_axis_tready, 0);
      tick();
      tick();
      rst = 1'b0;
      rd_chk("t6_ctrl", 12'h000, 32'h0000_0300);
      rd_chk("t6_pkt1", 12'h014, 32'd0);
      rd_chk("t6_status", 12'h004, 32'h0);
      clr_out();
      pend[0].push_back(2);
      wait_done("t6");
      chk("t6_nbeats", out_cyc.size(), 2);
      chk("t6_ch", out_ch.size() > 0 ? out_ch[0] : -1, 0);
      chk("t6_latency", out_cyc.size() > 0 ? out_cyc[0] - pkt_start[0] : -1, 2);
      rd_chk("t6_pkt0", 12'h010, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got running expected finished");
      $fatal(1, "watchdog");
   end
endmodule
